native_vtg: RTL and testbench
=============================

# native_vtg

Video timing generator for the HDMI output path. Produces the raster timing bundle (hsync, vsync, hblank, vblank, active, fid, ppl, lpf) consumed by the stream-to-native converter, which gates its buffer reads and aligns frames on it. The generator advances only on clock-enable cycles, so the downstream converter can act as timing master or slave. A start-of-frame pulse is provided for debug and frame-locking.

## Interface

- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch, pixels
- H_SYNC, 44, hsync width, pixels
- H_BP, 148, horizontal back porch, pixels
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch, lines
- V_SYNC, 5, vsync width, lines
- V_BP, 36, vertical back porch, lines
- HS_POL, 1, hsync asserted level
- VS_POL, 1, vsync asserted level
- CNT_WID, 12, counter and ppl/lpf width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- natv_clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  advance enable; position frozen when 0
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- hblank  out  1  horizontal blanking
- vblank  out  1  vertical blanking
- active  out  1  active video, equal to !hblank && !vblank
- fid  out  1  field id; toggles every frame
- ppl  out  CNT_WID  pixels per line, equal to H_ACTIVE
- lpf  out  CNT_WID  lines per frame, equal to V_ACTIVE
- sof  out  1  one-cycle pulse on pixel (0,0)

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the vertical parameters.
- Position (hcnt, vcnt): hcnt wraps from H_TOTAL-1 to 0. vcnt increments when hcnt wraps and itself wraps from V_TOTAL-1 to 0.
- Line order is active, then FP, then SYNC, then BP. Frame order is the same; pixel (0,0) is the first active pixel.
- Decode of the current position:
  - hblank = hcnt >= H_ACTIVE.
  - hsync is asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vblank = vcnt >= V_ACTIVE, held for the whole line.
  - vsync is asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, held for the whole line.
  - vblank and vsync change only together with the hcnt wrap to 0.
- At frame start, vblank and hblank fall in the same cycle. Downstream frame alignment depends on this.
- fid toggles when the position enters (0,0).
- sof = 1 only in the output cycle for (0,0).
- ce=0: counters hold and all outputs hold. sof is forced to 0 while ce=0.
- Reset values:
  - Counters: hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, so the first ce after reset enters (0,0).
  - Outputs: hsync=!HS_POL, vsync=!VS_POL, hblank=1, vblank=1, active=0, fid=0, sof=0, ppl=H_ACTIVE, lpf=V_ACTIVE.
- rst mid-line or mid-frame: immediate return to the reset values; no partial line completion.
- rst together with ce: rst wins.

## Timing

- All outputs are registered from the next-position decode, so the outputs and the position update on the same edge.
- Latency from a ce=1 sample to the new position's outputs is 1 cycle.
- Per-line output period is H_TOTAL ce-cycles; per-frame period is H_TOTAL*V_TOTAL ce-cycles.
- No combinational path from ce to any output.

## Structure

- Package vtg_pkg holds:
  - a timing struct {h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp, hs_pol, vs_pol};
  - constants VTG_1080P60 and VTG_720P60;
  - a function returning total = active+fp+sync+bp.
- Sub-module vtg_dim_cnt: a one-dimension wrap counter with step input, wrap output and blank/sync region decode. It is instantiated twice: horizontal stepped by ce, vertical stepped by ce && hwrap.

## Test plan

Small timing used for scenarios 1–5: H=8/2/3/3 (H_TOTAL=16), V=4/1/2/1 (V_TOTAL=8).

- Reset release, ce=1 → first output cycle has active=1, sof=1, hblank=vblank=0. Active lasts 8 cycles, then hblank for 8 cycles. hsync is asserted at hcnt 10–12.
- Run 3 frames, ce=1 → sof period 128 cycles, 32 active cycles per frame, vsync asserted on lines 5–6, fid toggles 0→1→0, vblank and hblank fall together at every sof.
- ce alternating 1/0 → sof period 256 cycles, all outputs stable during ce=0 cycles, sof width 1 cycle.
- rst asserted at hcnt=5, vcnt=2 → next cycle shows reset values. After release, the next output is (0,0) with sof=1.
- HS_POL=0, VS_POL=0 → hsync low only at hcnt 10–12, vsync low only on lines 5–6, both idle high in reset.
- Defaults (1080p60), ce=1 → 2200 cycles per line, 2475000 cycles per frame, ppl=1920, lpf=1080.

Source files
------------

// File: rtl/vtg_pkg.sv
// Shared timing definitions for the native video timing generator.
package vtg_pkg;

  localparam int unsigned VTG_DIM_WID = 16;

  typedef struct packed {
    logic [VTG_DIM_WID-1:0] h_active;
    logic [VTG_DIM_WID-1:0] h_fp;
    logic [VTG_DIM_WID-1:0] h_sync;
    logic [VTG_DIM_WID-1:0] h_bp;
    logic [VTG_DIM_WID-1:0] v_active;
    logic [VTG_DIM_WID-1:0] v_fp;
    logic [VTG_DIM_WID-1:0] v_sync;
    logic [VTG_DIM_WID-1:0] v_bp;
    logic                   hs_pol;
    logic                   vs_pol;
  } vtg_timing_t;

  localparam vtg_timing_t VTG_1080P60 = '{
    h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
    v_active: 16'd1080, v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  localparam vtg_timing_t VTG_720P60 = '{
    h_active: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
    v_active: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20,
    hs_pol: 1'b1, vs_pol: 1'b1
  };

  // Total extent of one dimension: active + front porch + sync + back porch.
  function automatic int unsigned vtg_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vtg_dim_cnt.sv
// One raster dimension: wrap counter plus blank/sync decode of the next count.
module vtg_dim_cnt
  import vtg_pkg::*;
#(
  parameter int unsigned CNT_WID    = 12,
  parameter int unsigned TOTAL      = 16,
  parameter int unsigned ACTIVE     = 8,
  parameter int unsigned SYNC_START = 10,
  parameter int unsigned SYNC_END   = 13
) (
  input  logic natv_clk,
  input  logic rst,
  input  logic step,
  output logic wrap_c,
  output logic blank_next_c,
  output logic sync_next_c
);

  localparam logic [CNT_WID-1:0] LAST    = CNT_WID'(TOTAL - 1);
  localparam logic [CNT_WID-1:0] ACT_END = CNT_WID'(ACTIVE);
  localparam logic [CNT_WID-1:0] SYNC_LO = CNT_WID'(SYNC_START);
  localparam logic [CNT_WID-1:0] SYNC_HI = CNT_WID'(SYNC_END);

  logic [CNT_WID-1:0] cnt;
  logic [CNT_WID-1:0] cnt_next;

  // Next count and region decode; decoding the next value lets the parent register outputs in step with the count.
  always_comb begin
    wrap_c   = step && (cnt == LAST);
    cnt_next = cnt;
    if (step) begin
      cnt_next = (cnt == LAST) ? '0 : cnt + CNT_WID'(1);
    end
    blank_next_c = (cnt_next >= ACT_END);
    sync_next_c  = (cnt_next >= SYNC_LO) && (cnt_next < SYNC_HI);
  end

  // Count register; reset parks on the last position so the first step lands on 0.
  always_ff @(posedge natv_clk) begin
    if (rst) begin
      cnt <= LAST;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/native_vtg.sv
// Native video timing generator: raster timing bundle advanced on clock enable.
module native_vtg
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(VTG_1080P60.h_active),
  parameter int unsigned H_FP     = 32'(VTG_1080P60.h_fp),
  parameter int unsigned H_SYNC   = 32'(VTG_1080P60.h_sync),
  parameter int unsigned H_BP     = 32'(VTG_1080P60.h_bp),
  parameter int unsigned V_ACTIVE = 32'(VTG_1080P60.v_active),
  parameter int unsigned V_FP     = 32'(VTG_1080P60.v_fp),
  parameter int unsigned V_SYNC   = 32'(VTG_1080P60.v_sync),
  parameter int unsigned V_BP     = 32'(VTG_1080P60.v_bp),
  parameter bit          HS_POL   = VTG_1080P60.hs_pol,
  parameter bit          VS_POL   = VTG_1080P60.vs_pol,
  parameter int unsigned CNT_WID  = 12
) (
  input  logic               natv_clk,
  input  logic               rst,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic               active,
  output logic               fid,
  output logic [CNT_WID-1:0] ppl,
  output logic [CNT_WID-1:0] lpf,
  output logic               sof
);

  localparam int unsigned H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic h_wrap;
  logic h_blank_nxt;
  logic h_sync_nxt;
  logic v_wrap;
  logic v_blank_nxt;
  logic v_sync_nxt;

  vtg_dim_cnt #(
    .CNT_WID   (CNT_WID),
    .TOTAL     (H_TOTAL),
    .ACTIVE    (H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END  (H_ACTIVE + H_FP + H_SYNC)
  ) u_hcnt (
    .natv_clk    (natv_clk),
    .rst         (rst),
    .step        (ce),
    .wrap_c      (h_wrap),
    .blank_next_c(h_blank_nxt),
    .sync_next_c (h_sync_nxt)
  );

  // Vertical steps only on a horizontal wrap, so its decode changes exactly at hcnt -> 0.
  vtg_dim_cnt #(
    .CNT_WID   (CNT_WID),
    .TOTAL     (V_TOTAL),
    .ACTIVE    (V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END  (V_ACTIVE + V_FP + V_SYNC)
  ) u_vcnt (
    .natv_clk    (natv_clk),
    .rst         (rst),
    .step        (h_wrap),
    .wrap_c      (v_wrap),
    .blank_next_c(v_blank_nxt),
    .sync_next_c (v_sync_nxt)
  );

  // Output register; a vertical wrap is the only way to enter (0,0), so it drives sof and fid.
  always_ff @(posedge natv_clk) begin
    if (rst) begin
      hsync  <= !HS_POL;
      vsync  <= !VS_POL;
      hblank <= 1'b1;
      vblank <= 1'b1;
      active <= 1'b0;
      fid    <= 1'b0;
      sof    <= 1'b0;
      ppl    <= CNT_WID'(H_ACTIVE);
      lpf    <= CNT_WID'(V_ACTIVE);
    end else begin
      sof <= 1'b0;
      ppl <= CNT_WID'(H_ACTIVE);
      lpf <= CNT_WID'(V_ACTIVE);
      if (ce) begin
        hsync  <= h_sync_nxt ? HS_POL : !HS_POL;
        vsync  <= v_sync_nxt ? VS_POL : !VS_POL;
        hblank <= h_blank_nxt;
        vblank <= v_blank_nxt;
        active <= !h_blank_nxt && !v_blank_nxt;
        sof    <= v_wrap;
        if (v_wrap) begin
          fid <= !fid;
        end
      end
    end
  end

endmodule

// File: tb/tb_native_vtg.sv
// Scoreboard bench for native_vtg: small positive/negative-polarity timings and 1080p defaults.
module tb_native_vtg;

  logic natv_clk;
  logic rst;
  logic ce;

  logic hsync_a, vsync_a, hblank_a, vblank_a, active_a, fid_a, sof_a;
  logic hsync_b, vsync_b, hblank_b, vblank_b, active_b, fid_b, sof_b;
  logic hsync_c, vsync_c, hblank_c, vblank_c, active_c, fid_c, sof_c;
  logic [11:0] ppl_a, lpf_a, ppl_b, lpf_b, ppl_c, lpf_c;

  native_vtg #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_WID(12)
  ) dut_a (
    .natv_clk(natv_clk), .rst(rst), .ce(ce),
    .hsync(hsync_a), .vsync(vsync_a), .hblank(hblank_a), .vblank(vblank_a),
    .active(active_a), .fid(fid_a), .ppl(ppl_a), .lpf(lpf_a), .sof(sof_a)
  );

  native_vtg #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_WID(12)
  ) dut_b (
    .natv_clk(natv_clk), .rst(rst), .ce(ce),
    .hsync(hsync_b), .vsync(vsync_b), .hblank(hblank_b), .vblank(vblank_b),
    .active(active_b), .fid(fid_b), .ppl(ppl_b), .lpf(lpf_b), .sof(sof_b)
  );

  native_vtg dut_c (
    .natv_clk(natv_clk), .rst(rst), .ce(ce),
    .hsync(hsync_c), .vsync(vsync_c), .hblank(hblank_c), .vblank(vblank_c),
    .active(active_c), .fid(fid_c), .ppl(ppl_c), .lpf(lpf_c), .sof(sof_c)
  );

  // Output vector layout: {hsync, vsync, hblank, vblank, active, fid, sof, ppl[11:0], lpf[11:0]}
  logic [30:0] act_a, act_b, act_c;
  assign act_a = {hsync_a, vsync_a, hblank_a, vblank_a, active_a, fid_a, sof_a, ppl_a, lpf_a};
  assign act_b = {hsync_b, vsync_b, hblank_b, vblank_b, active_b, fid_b, sof_b, ppl_b, lpf_b};
  assign act_c = {hsync_c, vsync_c, hblank_c, vblank_c, active_c, fid_c, sof_c, ppl_c, lpf_c};

  // Timing of each DUT: index 0 = dut_a, 1 = dut_b, 2 = dut_c
  int unsigned ha [3] = '{8, 8, 1920};
  int unsigned hfp[3] = '{2, 2, 88};
  int unsigned hsw[3] = '{3, 3, 44};
  int unsigned hbp[3] = '{3, 3, 148};
  int unsigned va [3] = '{4, 4, 1080};
  int unsigned vfp[3] = '{1, 1, 4};
  int unsigned vsw[3] = '{2, 2, 5};
  int unsigned vbp[3] = '{1, 1, 36};
  bit          hp [3] = '{1'b1, 1'b0, 1'b1};
  bit          vp [3] = '{1'b1, 1'b0, 1'b1};

  // Reference model state: linear position within the frame, field id, last output vector
  int unsigned mpos [3];
  bit          mfid [3];
  logic [30:0] mlast[3];

  logic [30:0] qa[$];
  logic [30:0] qb[$];
  logic [30:0] qc[$];

  int tests = 0;
  int fails = 0;
  int phase = 0;
  int cyc   = 0;

  initial natv_clk = 1'b0;
  always #5 natv_clk = ~natv_clk;

  function automatic int unsigned frame_len(input int d);
    return (ha[d] + hfp[d] + hsw[d] + hbp[d]) * (va[d] + vfp[d] + vsw[d] + vbp[d]);
  endfunction

  function automatic logic [30:0] decode(input int d, input int unsigned pos, input bit f, input bit s);
    int unsigned ht, h, v;
    bit hb, vb, hs_on, vs_on;
    ht    = ha[d] + hfp[d] + hsw[d] + hbp[d];
    h     = pos % ht;
    v     = pos / ht;
    hb    = (h >= ha[d]);
    vb    = (v >= va[d]);
    hs_on = (h >= ha[d] + hfp[d]) && (h < ha[d] + hfp[d] + hsw[d]);
    vs_on = (v >= va[d] + vfp[d]) && (v < va[d] + vfp[d] + vsw[d]);
    return {(hs_on ? hp[d] : !hp[d]), (vs_on ? vp[d] : !vp[d]), hb, vb, !hb && !vb, f, s,
            12'(ha[d]), 12'(va[d])};
  endfunction

  // Advance the model by one clock edge with the given inputs and queue the expected outputs.
  task automatic model_step(input bit r, input bit c);
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        mpos[d]  = frame_len(d) - 1;
        mfid[d]  = 1'b0;
        mlast[d] = {!hp[d], !vp[d], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'(ha[d]), 12'(va[d])};
      end else if (c) begin
        mpos[d] = (mpos[d] + 1) % frame_len(d);
        if (mpos[d] == 0) mfid[d] = !mfid[d];
        mlast[d] = decode(d, mpos[d], mfid[d], mpos[d] == 0);
      end else begin
        mlast[d][24] = 1'b0;
      end
      case (d)
        0:       qa.push_back(mlast[d]);
        1:       qb.push_back(mlast[d]);
        default: qc.push_back(mlast[d]);
      endcase
    end
  endtask

  task automatic drive(input bit r, input bit c);
    rst = r;
    ce  = c;
    model_step(r, c);
    @(negedge natv_clk);
  endtask

  task automatic chk_vec(input string name, input logic [30:0] act, input logic [30:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b (hs vs hb vb act fid sof ppl lpf)",
               name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop expected vectors after each edge and track sof / line periods.
  int last_sof   = -1;
  int sof_phase  = -1;
  int last_line  = -1;
  int line_phase = -1;
  bit hb_prev_c  = 1'b1;

  initial begin
    logic [30:0] e;
    forever begin
      @(posedge natv_clk);
      #1;
      cyc++;
      if (qa.size() > 0) begin e = qa.pop_front(); chk_vec("dut_a", act_a, e); end
      if (qb.size() > 0) begin e = qb.pop_front(); chk_vec("dut_b", act_b, e); end
      if (qc.size() > 0) begin e = qc.pop_front(); chk_vec("dut_c", act_c, e); end
      if (sof_a) begin
        if (last_sof >= 0 && sof_phase == phase && (phase == 2 || phase == 3))
          chk_int("sof_period", cyc - last_sof, (phase == 2) ? 128 : 256);
        last_sof  = cyc;
        sof_phase = phase;
      end
      if (hb_prev_c && !hblank_c) begin
        if (last_line >= 0 && line_phase == phase && phase == 6)
          chk_int("line_period_1080p", cyc - last_line, 2200);
        last_line  = cyc;
        line_phase = phase;
      end
      hb_prev_c = hblank_c;
    end
  end

  // Stimulus: directed phases followed by randomized enable/reset traffic.
  initial begin
    bit hit;
    rst = 1'b1;
    ce  = 1'b0;
    phase = 1;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);

    // Three full small frames with continuous enable
    phase = 2;
    for (int i = 0; i < 3 * 128; i++) drive(1'b0, 1'b1);

    // Alternating enable over three frames
    phase = 3;
    for (int i = 0; i < 3 * 256; i++) drive(1'b0, (i % 2) == 0);

    // Reset while dut_a sits at hcnt=5, vcnt=2, with ce high at the same time
    phase = 4;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (mpos[0] == 37) begin
        hit = 1'b1;
        break;
      end
      drive(1'b0, 1'b1);
    end
    if (!hit) chk_int("reach_mid_frame", int'(mpos[0]), 37);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1);

    // Random enable with occasional resets
    phase = 5;
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);

    // Continuous enable long enough to see several 1080p lines
    phase = 6;
    for (int i = 0; i < 7000; i++) drive(1'b0, 1'b1);

    phase = 7;
    rst = 1'b0;
    ce  = 1'b0;
    repeat (3) @(negedge natv_clk);
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0)
      chk_int("queue_drain", qa.size() + qb.size() + qc.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
